// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage memory controller.
// Holds the pipeline value/register-address widths, the external SRAM
// geometry, and the state encoding of the SRAM pin sequencer.
package mem_ctrl_pkg;

  localparam int REG_VALUE_W = 16;  // width of a register value / ALU result
  localparam int REG_ADDR_W  = 5;   // width of a register-file index
  localparam int SRAM_ADDR_W = 18;  // external SRAM address bus
  localparam int SRAM_DATA_W = 16;  // external SRAM data bus

  // Zero-extension applied to the ALU result to form the SRAM address.
  localparam int SRAM_ADDR_PAD = SRAM_ADDR_W - REG_VALUE_W;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ADDR  = 3'd1,
    ST_RD_DATA  = 3'd2,
    ST_WR_ADDR  = 3'd3,
    ST_WR_PULSE = 3'd4,
    ST_WR_REC   = 3'd5,
    ST_DONE     = 3'd6
  } seq_state_e;

  // True while an SRAM access is actually in flight (chip enabled).
  function automatic logic in_access(input seq_state_e s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/sram_seq.sv
// SRAM pin sequencer.
// Turns a single-cycle read/write request into the asynchronous SRAM pin
// protocol. Read: RD_ADDR -> RD_DATA -> DONE. Write: WR_ADDR -> WR_PULSE ->
// WR_REC -> DONE. A write request wins over a simultaneous read request.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   mem_read, mem_write    request, sampled while IDLE
//   addr, wdata            address (ALU result) and store data
//   idle, busy, done       sequencer status (busy = access in flight)
//   done_read              in DONE after a read; rdata is then valid
//   rdata                  registered read data
//   ram_*                  SRAM pins (control pins active-low)
module sram_seq
  import mem_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [REG_VALUE_W-1:0] addr,
  input  logic [REG_VALUE_W-1:0] wdata,
  output logic                   idle,
  output logic                   busy,
  output logic                   done,
  output logic                   done_read,
  output logic [SRAM_DATA_W-1:0] rdata,
  output logic [SRAM_ADDR_W-1:0] ram_addr,
  output logic [SRAM_DATA_W-1:0] ram_dout,
  input  logic [SRAM_DATA_W-1:0] ram_din,
  output logic                   ram_doe,
  output logic                   ram_oe_n,
  output logic                   ram_we_n,
  output logic                   ram_en_n
);

  seq_state_e state_q;
  seq_state_e state_d;
  logic       is_read_q;
  logic       start;

  assign start = (state_q == ST_IDLE) && (mem_read || mem_write);

  // Pin controls are decoded straight from the state register, so an
  // asynchronous reset drops write-enable and bus drive immediately.
  always_comb begin
    // NOTE: every output of this block gets a default first; otherwise a
    // path that skips an assignment infers a latch.
    state_d  = state_q;
    ram_doe  = 1'b0;
    ram_oe_n = 1'b1;
    ram_we_n = 1'b1;
    ram_en_n = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_write)     state_d = ST_WR_ADDR;
        else if (mem_read) state_d = ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        state_d  = ST_RD_DATA;
        ram_oe_n = 1'b0;
        ram_en_n = 1'b0;
      end
      ST_RD_DATA: begin
        state_d  = ST_DONE;
        ram_oe_n = 1'b0;
        ram_en_n = 1'b0;
      end
      ST_WR_ADDR: begin
        state_d  = ST_WR_PULSE;
        ram_doe  = 1'b1;
        ram_en_n = 1'b0;
      end
      ST_WR_PULSE: begin
        state_d  = ST_WR_REC;
        ram_doe  = 1'b1;
        ram_we_n = 1'b0;
        ram_en_n = 1'b0;
      end
      ST_WR_REC: begin
        state_d  = ST_DONE;
        ram_doe  = 1'b1;
        ram_en_n = 1'b0;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      ram_addr  <= '0;
      ram_dout  <= '0;
      is_read_q <= 1'b0;
      rdata     <= '0;
    end else begin
      state_q <= state_d;
      // Address and store data are frozen for the whole access.
      if (start) begin
        ram_addr  <= {{SRAM_ADDR_PAD{1'b0}}, addr};
        ram_dout  <= wdata;
        is_read_q <= !mem_write;
      end
      // Data is taken from the bus at the end of the second OE-low cycle.
      if (state_q == ST_RD_DATA) rdata <= ram_din;
    end
  end

  assign idle      = (state_q == ST_IDLE);
  assign busy      = in_access(state_q);
  assign done      = (state_q == ST_DONE);
  assign done_read = done && is_read_q;

endmodule

// File: rtl/mem_ctrl.sv
// MEM pipeline stage with an external asynchronous SRAM.
// Stalls earlier stages while an SRAM access runs, then releases the
// instruction into the MEM/WB register with either the loaded data or the
// ALU result. Counts completed SRAM accesses.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   mem_read, mem_write              memory request from EXE
//   addr, wdata                      ALU result / address, store data
//   reg_write, reg_addr              writeback control, passed through
//   hold                             combinational stall to ID/EXE and earlier
//   reg_write_out, reg_addr_out,
//   result_out                       registered MEM/WB fields
//   ram_addr, ram_dout, ram_din,
//   ram_doe, ram_oe_n, ram_we_n,
//   ram_en_n                         SRAM interface
//   acc_cnt                          completed-access counter (wraps)
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [REG_VALUE_W-1:0] addr,
  input  logic [REG_VALUE_W-1:0] wdata,
  input  logic                   reg_write,
  input  logic [REG_ADDR_W-1:0]  reg_addr,
  output logic                   hold,
  output logic                   reg_write_out,
  output logic [REG_ADDR_W-1:0]  reg_addr_out,
  output logic [REG_VALUE_W-1:0] result_out,
  output logic [SRAM_ADDR_W-1:0] ram_addr,
  output logic [SRAM_DATA_W-1:0] ram_dout,
  input  logic [SRAM_DATA_W-1:0] ram_din,
  output logic                   ram_doe,
  output logic                   ram_oe_n,
  output logic                   ram_we_n,
  output logic                   ram_en_n,
  output logic [31:0]            acc_cnt
);

  logic                   seq_idle;
  logic                   seq_busy;
  logic                   seq_done;
  logic                   seq_done_read;
  logic [SRAM_DATA_W-1:0] seq_rdata;

  sram_seq u_sram_seq (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .idle      (seq_idle),
    .busy      (seq_busy),
    .done      (seq_done),
    .done_read (seq_done_read),
    .rdata     (seq_rdata),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din),
    .ram_doe   (ram_doe),
    .ram_oe_n  (ram_oe_n),
    .ram_we_n  (ram_we_n),
    .ram_en_n  (ram_en_n)
  );

  // Stall from the cycle a memory instruction arrives until DONE. In DONE
  // the same instruction is still presented but is released this edge, so
  // a non-memory instruction never stalls.
  assign hold = (seq_idle && (mem_read || mem_write)) || seq_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_out <= 1'b0;
      reg_addr_out  <= '0;
      result_out    <= '0;
    end else if (hold) begin
      // Bubble: nothing writes back while stalled.
      reg_write_out <= 1'b0;
    end else begin
      reg_write_out <= reg_write;
      reg_addr_out  <= reg_addr;
      result_out    <= seq_done_read ? seq_rdata : addr;
    end
  end

  // Only completed accesses count: a reset mid-access never reaches DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           acc_cnt <= '0;
    else if (seq_done) acc_cnt <= acc_cnt + 32'd1;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized scoreboard bench for mem_ctrl with a behavioural SRAM model.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   mem_read = 1'b0;
  logic                   mem_write = 1'b0;
  logic [REG_VALUE_W-1:0] addr = '0;
  logic [REG_VALUE_W-1:0] wdata = '0;
  logic                   reg_write = 1'b0;
  logic [REG_ADDR_W-1:0]  reg_addr = '0;
  logic                   hold;
  logic                   reg_write_out;
  logic [REG_ADDR_W-1:0]  reg_addr_out;
  logic [REG_VALUE_W-1:0] result_out;
  logic [SRAM_ADDR_W-1:0] ram_addr;
  logic [SRAM_DATA_W-1:0] ram_dout;
  logic [SRAM_DATA_W-1:0] ram_din = 16'hDEAD;
  logic                   ram_doe;
  logic                   ram_oe_n;
  logic                   ram_we_n;
  logic                   ram_en_n;
  logic [31:0]            acc_cnt;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .reg_write(reg_write), .reg_addr(reg_addr),
    .hold(hold), .reg_write_out(reg_write_out), .reg_addr_out(reg_addr_out),
    .result_out(result_out), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .ram_din(ram_din), .ram_doe(ram_doe), .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n), .ram_en_n(ram_en_n), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                   reg_write;
    logic [REG_ADDR_W-1:0]  reg_addr;
    logic [REG_VALUE_W-1:0] result;
  } exp_t;

  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_en  = 1'b0;
  logic [31:0] exp_acc = '0;

  // Reference memory (what the program has stored) and the SRAM device.
  logic [SRAM_DATA_W-1:0] ref_mem [logic [REG_VALUE_W-1:0]];
  logic [SRAM_DATA_W-1:0] sram    [logic [SRAM_ADDR_W-1:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [SRAM_DATA_W-1:0] ref_rd(input logic [REG_VALUE_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'h5A5A);
  endfunction

  // SRAM device: stores on a WE-low cycle, drives data while OE is low.
  always @(negedge clk) begin
    if (!ram_en_n && !ram_we_n) sram[ram_addr] = ram_dout;
    if (!ram_en_n && !ram_oe_n)
      ram_din = sram.exists(ram_addr) ? sram[ram_addr] : (ram_addr[15:0] ^ 16'h5A5A);
    else
      ram_din = 16'hDEAD;
  end

  // Monitor: every edge with hold low releases one instruction into MEM/WB.
  initial begin
    logic h;
    exp_t e;
    forever begin
      @(negedge clk);
      h = hold;
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (h) begin
          check("bubble_reg_write_out", 32'(reg_write_out), 32'd0);
        end else if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: result_out=0x%0h with no pending instruction", result_out);
        end else begin
          e = sb.pop_front();
          check("reg_write_out", 32'(reg_write_out), 32'(e.reg_write));
          check("reg_addr_out", 32'(reg_addr_out), 32'(e.reg_addr));
          check("result_out", 32'(result_out), 32'(e.result));
        end
      end
    end
  end

  // Present one instruction; returns at posedge+1 after the edge accepting it.
  task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] wd, input logic rw, input logic [4:0] ra);
    exp_t e;
    int hold_n = 0, oe_n = 0, we_n = 0, doe_n = 0, en_n = 0;
    bit acc = 1'b0;
    mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    reg_write = rw; reg_addr = ra;
    e.reg_write = rw;
    e.reg_addr  = ra;
    if (wr) begin
      e.result   = a;
      ref_mem[a] = wd;
    end else if (rd) begin
      e.result = ref_rd(a);
    end else begin
      e.result = a;
    end
    sb.push_back(e);
    for (int c = 0; c < 12 && !acc; c++) begin
      @(negedge clk);
      if (hold) hold_n++; else acc = 1'b1;
      if (!ram_en_n) begin
        en_n++;
        check("ram_addr", 32'(ram_addr), 32'({2'b00, a}));
      end
      if (!ram_oe_n) oe_n++;
      if (ram_doe) begin
        doe_n++;
        check("ram_dout", 32'(ram_dout), 32'(wd));
      end
      if (!ram_we_n) begin
        we_n++;
        check("ram_doe_at_we", 32'(ram_doe), 32'd1);
      end
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: hold still 1 after 12 cycles, addr=0x%0h", a);
    end
    if (rd || wr) exp_acc = exp_acc + 32'd1;
    check("hold_cycles", 32'(hold_n), wr ? 32'd4 : (rd ? 32'd3 : 32'd0));
    check("oe_low_cycles", 32'(oe_n), (rd && !wr) ? 32'd2 : 32'd0);
    check("we_low_cycles", 32'(we_n), wr ? 32'd1 : 32'd0);
    check("doe_cycles", 32'(doe_n), wr ? 32'd3 : 32'd0);
    check("en_low_cycles", 32'(en_n), wr ? 32'd3 : (rd ? 32'd2 : 32'd0));
    check("acc_cnt", acc_cnt, exp_acc);
  endtask

  task automatic start_stream();
    @(posedge clk);
    #2;
    mon_en = 1'b1;
  endtask

  task automatic end_stream();
    #1;
    mon_en    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int kind;
    logic [15:0] a;

    // Reset values.
    #1;
    check("rst_hold", 32'(hold), 32'd0);
    check("rst_reg_write_out", 32'(reg_write_out), 32'd0);
    check("rst_reg_addr_out", 32'(reg_addr_out), 32'd0);
    check("rst_result_out", 32'(result_out), 32'd0);
    check("rst_acc_cnt", acc_cnt, 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_dout", 32'(ram_dout), 32'd0);
    check("rst_ram_doe", 32'(ram_doe), 32'd0);
    check("rst_ram_oe_n", 32'(ram_oe_n), 32'd1);
    check("rst_ram_we_n", 32'(ram_we_n), 32'd1);
    check("rst_ram_en_n", 32'(ram_en_n), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset asserted during the write pulse.
    @(posedge clk);
    #1;
    mem_write = 1'b1; addr = 16'hFFF0; wdata = 16'h3C3C;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (!ram_we_n) seen = 1'b1;
    end
    check("abort_we_pulse_seen", 32'(seen), 32'd1);
    #1;
    rst = 1'b1;
    mem_write = 1'b0;
    #1;
    check("abort_ram_we_n", 32'(ram_we_n), 32'd1);
    check("abort_ram_doe", 32'(ram_doe), 32'd0);
    check("abort_ram_en_n", 32'(ram_en_n), 32'd1);
    check("abort_hold", 32'(hold), 32'd0);
    check("abort_acc_cnt", acc_cnt, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_acc_cnt_after", acc_cnt, 32'd0);
    check("abort_idle_en_n", 32'(ram_en_n), 32'd1);

    // Directed instructions, then a randomized stream.
    sram[18'h01234]    = 16'hBEEF;
    ref_mem[16'h1234]  = 16'hBEEF;
    start_stream();
    issue(1'b0, 1'b0, 16'h0042, 16'h0000, 1'b1, 5'd3);
    issue(1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 5'd7);
    issue(1'b0, 1'b1, 16'h8000, 16'h00A5, 1'b0, 5'd0);
    issue(1'b1, 1'b1, 16'h2222, 16'h1357, 1'b0, 5'd1);
    issue(1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1, 5'd9);
    issue(1'b1, 1'b0, 16'h2222, 16'h0000, 1'b1, 5'd10);
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 3));
      a    = (kind == 0) ? 16'($urandom) : 16'($urandom_range(0, 15) * 16'h1111);
      issue(kind[0], kind[1], a, 16'($urandom), 1'($urandom), 5'($urandom));
    end
    end_stream();

    // Counter wrap: preload the counter, then one more completed read.
    force dut.acc_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.acc_cnt;
    #1;
    check("acc_cnt_preload", acc_cnt, 32'hFFFF_FFFF);
    exp_acc = 32'hFFFF_FFFF;
    start_stream();
    issue(1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 5'd31);
    end_stream();

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
